// File: rtl/aes_round_seq.sv
// aes_round_seq: sequences one AES block through an external round datapath.
// The block XORs the plaintext with round key 0, then issues NR rounds, one at
// a time, to the datapath. It waits for each result, and presents the final
// state as ciphertext.
// Optional feature: define AES_SEQ_TIMEOUT_EN to add a per-round WAIT timeout.
// On timeout the block sets a sticky err flag and returns to IDLE.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | ready for a plaintext block; whitening key (index 0) selected
//  ISSUE | one-cycle launch of the current round to the datapath
//  WAIT  | datapath inputs held until rnd_dataout_valid
//  DONE  | ciphertext presented until out_ready
module aes_round_seq #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] key_in,
    output logic         rnd_en,
    output logic         rnd_final,
    output logic [127:0] rnd_datain,
    output logic [127:0] rnd_keyin,
    input  logic [127:0] rnd_dataout,
    input  logic         rnd_dataout_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_cnt,
    output logic         err
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [127:0]   state_reg;
    logic           accept;
    logic           round_done;
    logic           last_round;
    logic           timeout;

    // The key store is combinational, so key_in follows key_idx in the same cycle.
    // The datapath therefore sees the key for the round it is working on.
    assign rnd_datain = state_reg;
    assign rnd_keyin  = key_in;

    assign accept     = (state == S_IDLE) && in_valid;
    assign round_done = (state == S_WAIT) && rnd_dataout_valid;
    assign last_round = (round_cnt == NR_L);

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    // The timeout fires on the TIMEOUT-th consecutive WAIT cycle without a result.
    assign timeout = (state == S_WAIT) && !rnd_dataout_valid && (to_cnt == TO_LAST);
    assign err     = err_q;

    // WAIT-cycle counter and the sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                to_cnt <= '0;
            end else if ((state == S_WAIT) && !rnd_dataout_valid && !timeout) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (rnd_dataout_valid) begin
                    state_nxt = last_round ? S_DONE : S_ISSUE;
                end else if (timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; ISSUE and WAIT drive identical datapath controls
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        rnd_en    = 1'b0;
        rnd_final = 1'b0;
        key_idx   = 4'd0;
        out_valid = 1'b0;
        out_data  = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_ISSUE, S_WAIT: begin
                rnd_en    = 1'b1;
                key_idx   = round_cnt;
                rnd_final = last_round;
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_data  = state_reg;
            end
            default: ;
        endcase
    end

    // Cipher state and round counter: whitening on accept, result capture in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            round_cnt <= 4'd0;
        end else if (accept) begin
            state_reg <= in_data ^ key_in;
            round_cnt <= 4'd1;
        end else if (round_done) begin
            state_reg <= rnd_dataout;
            if (!last_round) round_cnt <= round_cnt + 4'd1;
        end
    end

endmodule

// File: doc/aes_round_seq.md
AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds; legal range 1..14.
REQ-002 Parameter TIMEOUT, default 15, maximum WAIT cycles per round; used only when AES_SEQ_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock for the block; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid / in_ready / in_data  in / out / in  1/1/128  plaintext block handshake.
REQ-006 key_idx  out  4  round-key index presented to the external key store.
REQ-007 key_in  in  128  round key for key_idx, valid in the same cycle (combinational store).
REQ-008 rnd_en / rnd_final  out  1/1  round datapath enable; final-round select (datapath skips MixColumns).
REQ-009 rnd_datain / rnd_keyin  out  128/128  state and round key driven to the round datapath.
REQ-010 rnd_dataout / rnd_dataout_valid  in  128/1  round datapath result and its one-cycle valid pulse.
REQ-011 out_valid / out_ready / out_data  out / in / out  1/1/128  ciphertext handshake.
REQ-012 busy  out  1  high in any state other than IDLE; round_cnt  out  4  current round number.
REQ-013 err  out  1  round-timeout flag (see Configuration).

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, DONE; one-hot or binary encoding is free.
REQ-015 IDLE: in_ready=1, key_idx=0; on in_valid&&in_ready, state_reg <= in_data ^ key_in, round_cnt <= 1, next state ISSUE.
REQ-016 ISSUE: one cycle; rnd_en=1, rnd_datain=state_reg, key_idx=round_cnt, rnd_keyin=key_in, rnd_final=(round_cnt==NR); next state WAIT.
REQ-017 WAIT: rnd_en, rnd_datain, key_idx, rnd_keyin and rnd_final held at their ISSUE values until rnd_dataout_valid.
REQ-018 WAIT with rnd_dataout_valid: state_reg <= rnd_dataout; round_cnt==NR goes to DONE; otherwise round_cnt <= round_cnt+1 and next state ISSUE.
REQ-019 rnd_dataout_valid is ignored in IDLE, ISSUE and DONE.
REQ-020 rnd_en=0 in IDLE and DONE.
REQ-021 DONE: out_valid=1, out_data=state_reg, held stable until out_ready; on out_valid&&out_ready, next state IDLE.
REQ-022 in_ready=0 in every state except IDLE; there is no input/output overlap and only one block is in flight.
REQ-023 Throughput: NR*(1+L)+2 cycles per block for a datapath latency of L cycles from ISSUE, assuming out_ready=1 on entry to DONE.
REQ-024 round_cnt is 4-bit unsigned and never exceeds NR; it does not wrap.
REQ-025 in_valid is sampled only in IDLE; in_data is captured only on the accepting edge.

Reset
REQ-026 rst_n low forces, asynchronously: state IDLE, state_reg=0, round_cnt=0, key_idx=0, rnd_en=0, rnd_final=0, out_valid=0, out_data=0, err=0, busy=0; in_ready=1 after release.
REQ-027 Reset asserted mid-block (ISSUE/WAIT/DONE) discards the block; no out_valid follows for it.

Configuration
REQ-028 Macro AES_SEQ_TIMEOUT_EN defined: a cycle counter clears on ISSUE and increments in WAIT; reaching TIMEOUT without rnd_dataout_valid sets err=1, drops rnd_en, and returns to IDLE without out_valid.
REQ-029 err is sticky and clears on the next accepted input block or on reset.
REQ-030 Macro undefined: no counter is implemented, WAIT waits indefinitely, and err is tied to 0.

Verification
REQ-031 FIPS-197 C.1: key 000102..0f (expanded in the key store), in_data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, with rnd_final=1 only in round 10.
REQ-032 Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable, in_ready=0, busy=1 throughout.
REQ-033 Back-to-back: two blocks with in_valid held high and out_ready=1 -> the second is accepted the cycle after the first out handshake, and both ciphertexts are correct.
REQ-034 Reset pulse during WAIT of round 5 -> all outputs at reset values immediately, no out_valid, and the next block completes correctly.
REQ-035 Stray rnd_dataout_valid during IDLE and ISSUE -> state_reg and round_cnt unchanged.
REQ-036 AES_SEQ_TIMEOUT_EN defined with the datapath stalled in round 3 -> err=1 after 15 WAIT cycles, rnd_en=0, state IDLE; the next accepted block clears err.
